decade_counter_ld: RTL and testbench

//  Multi-digit up/down counter with parallel load, radix per digit set by parameter
//  (decimal by default, i.e. a chain of decade/dekatron-style digits).

---
 rtl/dpc_counter_pkg.sv | 24 ++
 rtl/decade_counter_ld_if.sv | 13 +
 rtl/radix_digit.sv | 29 ++
 rtl/decade_counter_ld.sv | 69 ++++++
 tb/tb_decade_counter_ld.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/dpc_counter_pkg.sv
// dpc_counter_pkg: shared sizing helpers and config checks for the radix counter chain
package dpc_counter_pkg;
   localparam int MAX_BITS = 64;
   localparam int MAX_DW   = 8;

   function automatic int digit_w(input int radix);
      return $clog2(radix);
   endfunction

   function automatic bit radix_ok(input int radix);
      return radix >= 2 && radix <= 16;
   endfunction

   function automatic logic [MAX_BITS-1:0] all_max_pattern(input int digits, input int radix, input int w);
      logic [MAX_BITS-1:0] p;
      p = '0;
      for (int i = 0; i < digits; i++) p = p | (MAX_BITS'(radix - 1) << (i * w));
      return p;
   endfunction

   function automatic logic [MAX_DW-1:0] digit_of(input logic [MAX_BITS-1:0] v, input int i, input int w);
      return MAX_DW'((v >> (i * w)) & ((MAX_BITS'(1) << w) - MAX_BITS'(1)));
   endfunction
endpackage

// File: rtl/decade_counter_ld_if.sv
// decade_counter_ld_if: request/load inputs and count/flag outputs of the counter chain
interface decade_counter_ld_if #(parameter int DIGITS = 4, parameter int DIGIT_W = 4);
   logic                      up;
   logic                      down;
   logic                      ld;
   logic [DIGITS*DIGIT_W-1:0] ld_data;
   logic [DIGITS*DIGIT_W-1:0] count;
   logic                      carry;
   logic                      borrow;
   logic                      zero;
   modport master (output up, down, ld, ld_data, input count, carry, borrow, zero);
   modport slave  (input up, down, ld, ld_data, output count, carry, borrow, zero);
endinterface

// File: rtl/radix_digit.sv
// radix_digit: one counter digit with clamped load and wrap within 0..RADIX-1
module radix_digit #(
   parameter int RADIX   = 10,
   parameter int DIGIT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc_en,
   input  logic               dec_en,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_val,
   output logic [DIGIT_W-1:0] digit,
   output logic               at_max,
   output logic               at_zero
);
   localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(RADIX - 1);
   logic [DIGIT_W-1:0] nxt;
   assign at_max  = digit == TOP;
   assign at_zero = digit == '0;
   // next digit: load (clamped) beats step; stepping past an end folds to the other end
   always_comb
      nxt = ld     ? (ld_val > TOP ? TOP : ld_val) :
            inc_en ? (at_max  ? '0  : digit + 1'b1) :
            dec_en ? (at_zero ? TOP : digit - 1'b1) : digit;
   // digit register, falling-edge clocked with async clear
   always_ff @(negedge clk or negedge rst_n)
      if (!rst_n) digit <= '0;
      else        digit <= nxt;
endmodule

// File: rtl/decade_counter_ld.sv
// decade_counter_ld: multi-digit up/down counter with lookahead carry, clamped load and cascade pulses
module decade_counter_ld
   import dpc_counter_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int RADIX   = 10,
   parameter int DIGIT_W = 4,
   parameter int WRAP    = 1
) (
   input logic                CLOCK,
   input logic                RST,
   decade_counter_ld_if.slave bus
);
   localparam int N = DIGITS * DIGIT_W;

   if (!radix_ok(RADIX) || digit_w(RADIX) > DIGIT_W) begin : g_bad_cfg
      $error("decade_counter_ld: RADIX must be 2..16 and fit in DIGIT_W bits");
   end

   logic [DIGITS-1:0] at_max, at_zero, inc_en, dec_en;
   logic [DIGITS:0]   max_chain, zero_chain;
   logic [N-1:0]      count_q;
   logic              step_up, step_dn, carry_nxt, borrow_nxt, hold_end;
   logic              carry_q, borrow_q;

   assign max_chain[0]  = 1'b1;
   assign zero_chain[0] = 1'b1;
   assign bus.count     = count_q;
   assign bus.carry     = carry_q;
   assign bus.borrow    = borrow_q;
   assign bus.zero      = zero_chain[DIGITS];

   // request decode with load priority, end-of-range detection and the saturate hold
   always_comb begin
      step_up    = bus.up & ~bus.down & ~bus.ld;
      step_dn    = bus.down & ~bus.up & ~bus.ld;
      carry_nxt  = step_up & max_chain[DIGITS];
      borrow_nxt = step_dn & zero_chain[DIGITS];
      hold_end   = (carry_nxt | borrow_nxt) & (WRAP == 0);
   end

   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      assign max_chain[d+1]  = max_chain[d] & at_max[d];
      assign zero_chain[d+1] = zero_chain[d] & at_zero[d];
      assign inc_en[d]       = step_up & max_chain[d] & ~hold_end;
      assign dec_en[d]       = step_dn & zero_chain[d] & ~hold_end;
      radix_digit #(.RADIX(RADIX), .DIGIT_W(DIGIT_W)) u_digit (
         .clk    (CLOCK),
         .rst_n  (RST),
         .inc_en (inc_en[d]),
         .dec_en (dec_en[d]),
         .ld     (bus.ld),
         .ld_val (DIGIT_W'(digit_of(MAX_BITS'(bus.ld_data), d, DIGIT_W))),
         .digit  (count_q[d*DIGIT_W +: DIGIT_W]),
         .at_max (at_max[d]),
         .at_zero(at_zero[d])
      );
   end

   // one-cycle cascade pulses registered on the same edge as the count
   always_ff @(negedge CLOCK or negedge RST)
      if (!RST) begin
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         carry_q  <= carry_nxt;
         borrow_q <= borrow_nxt;
      end
endmodule

// File: tb/tb_decade_counter_ld.sv
// tb_decade_counter_ld: scoreboard bench for wrap, saturate and radix-6 counter variants
module tb_decade_counter_ld;
   logic        clk = 1'b1;
   logic        rst_n = 1'b0;
   logic        up = 1'b0, down = 1'b0, ld = 1'b0;
   logic [15:0] ld16 = '0;
   logic [7:0]  ld8 = '0;
   int          checks = 0, failures = 0;

   typedef struct {
      string       tag;
      logic [15:0] c4w, c4s;
      logic [7:0]  c6;
      logic [2:0]  cy, bw, z;
   } exp_t;
   exp_t sb[$];

   int m4w = 0, m4s = 0, m6 = 0;
   bit cy4w, bw4w, cy4s, bw4s, cy6, bw6;

   always #5 clk = ~clk;

   decade_counter_ld_if #(.DIGITS(4), .DIGIT_W(4)) if4w();
   decade_counter_ld_if #(.DIGITS(4), .DIGIT_W(4)) if4s();
   decade_counter_ld_if #(.DIGITS(2), .DIGIT_W(4)) if6();

   assign {if4w.up, if4w.down, if4w.ld, if4w.ld_data} = {up, down, ld, ld16};
   assign {if4s.up, if4s.down, if4s.ld, if4s.ld_data} = {up, down, ld, ld16};
   assign {if6.up,  if6.down,  if6.ld,  if6.ld_data}  = {up, down, ld, ld8};

   decade_counter_ld #(.DIGITS(4), .RADIX(10), .DIGIT_W(4), .WRAP(1)) u_4w (.CLOCK(clk), .RST(rst_n), .bus(if4w.slave));
   decade_counter_ld #(.DIGITS(4), .RADIX(10), .DIGIT_W(4), .WRAP(0)) u_4s (.CLOCK(clk), .RST(rst_n), .bus(if4s.slave));
   decade_counter_ld #(.DIGITS(2), .RADIX(6),  .DIGIT_W(4), .WRAP(1)) u_6  (.CLOCK(clk), .RST(rst_n), .bus(if6.slave));

   function automatic int nxt(input int v, input bit u, input bit dn, input bit l, input logic [15:0] data,
                              input int dg, input int r, input bit wrap, output bit c, output bit b);
      int mx, acc, p;
      mx = r ** dg - 1;
      acc = 0;
      p = 1;
      c = 0;
      b = 0;
      if (l) begin
         for (int i = 0; i < dg; i++) begin
            int d;
            d = int'(data[i*4 +: 4]);
            acc += (d >= r ? r - 1 : d) * p;
            p *= r;
         end
         return acc;
      end
      if (u && dn) return v;
      if (u) begin
         if (v == mx) begin c = 1; return wrap ? 0 : mx; end
         return v + 1;
      end
      if (dn) begin
         if (v == 0) begin b = 1; return wrap ? mx : 0; end
         return v - 1;
      end
      return v;
   endfunction

   function automatic logic [15:0] to_pack(input int v, input int dg, input int r);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < dg; i++) begin
         p[i*4 +: 4] = 4'(v % r);
         v = v / r;
      end
      return p;
   endfunction

   function automatic exp_t snap(input string tag);
      exp_t e;
      e.tag = tag;
      e.c4w = to_pack(m4w, 4, 10);
      e.c4s = to_pack(m4s, 4, 10);
      e.c6  = 8'(to_pack(m6, 2, 6));
      e.cy  = {cy4w, cy4s, cy6};
      e.bw  = {bw4w, bw4s, bw6};
      e.z   = {m4w == 0, m4s == 0, m6 == 0};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_compare();
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "/4w.count"}, if4w.count, e.c4w);
      chk({e.tag, "/4s.count"}, if4s.count, e.c4s);
      chk({e.tag, "/r6.count"}, 16'(if6.count), 16'(e.c6));
      chk({e.tag, "/carry"},  16'({if4w.carry, if4s.carry, if6.carry}), 16'(e.cy));
      chk({e.tag, "/borrow"}, 16'({if4w.borrow, if4s.borrow, if6.borrow}), 16'(e.bw));
      chk({e.tag, "/zero"},   16'({if4w.zero, if4s.zero, if6.zero}), 16'(e.z));
   endtask

   task automatic step(input string tag);
      m4w = nxt(m4w, up, down, ld, ld16, 4, 10, 1'b1, cy4w, bw4w);
      m4s = nxt(m4s, up, down, ld, ld16, 4, 10, 1'b0, cy4s, bw4s);
      m6  = nxt(m6, up, down, ld, {8'h00, ld8}, 2, 6, 1'b1, cy6, bw6);
      sb.push_back(snap(tag));
      @(negedge clk);
      #1;
      pop_compare();
   endtask

   task automatic reset_now(input string tag);
      m4w = 0; m4s = 0; m6 = 0;
      {cy4w, bw4w, cy4s, bw4s, cy6, bw6} = '0;
      sb.push_back(snap(tag));
      #1;
      pop_compare();
   endtask

   task automatic load(input string tag, input logic [15:0] d16, input logic [7:0] d8);
      {up, down, ld, ld16, ld8} = {1'b0, 1'b0, 1'b1, d16, d8};
      step(tag);
      ld = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #11;
      reset_now("reset_init");
      rst_n = 1'b1;
      load("ld_0120", 16'h0120, 8'h12);
      up = 1'b1;
      for (int i = 0; i < 3; i++) step("up_to_0123");
      rst_n = 1'b0;
      reset_now("reset_mid");
      #3 rst_n = 1'b1;
      step("first_after_rst");
      load("ld_0099", 16'h0099, 8'h55);
      up = 1'b1;
      step("up_0099");
      load("ld_9999", 16'h9999, 8'h55);
      up = 1'b1;
      step("up_wrap");
      up = 1'b0;
      step("carry_drop");
      up = 1'b1;
      step("up_sat_again");
      up = 1'b0;
      load("ld_0100", 16'h0100, 8'h10);
      down = 1'b1;
      step("dn_0100");
      load("ld_0000", 16'h0000, 8'h00);
      down = 1'b1;
      step("dn_wrap");
      down = 1'b0;
      step("borrow_drop");
      load("ld_clamp", 16'hA5F3, 8'hF7);
      {up, ld, ld16, ld8} = {1'b1, 1'b1, 16'hA5F3, 8'h3A};
      step("ld_beats_up");
      {up, ld} = 2'b00;
      load("ld_0457", 16'h0457, 8'h24);
      {up, down} = 2'b11;
      for (int i = 0; i < 3; i++) step("up_dn_hold");
      for (int i = 0; i < 10000; i++) begin
         up   = 1'($urandom_range(0, 1));
         down = 1'($urandom_range(0, 1));
         ld   = $urandom_range(0, 7) == 0;
         ld16 = 16'($urandom);
         ld8  = 8'($urandom);
         step("random");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
